// File: rtl/sr_drive_check.sv
// Drives S/R of a downstream SR flop, samples Q after SETTLE cycles and scores it against a reference model.
// Optional feature macro: SR_DRIVE_CHECK_STICKY_ERR_EN adds the err_sticky output.
module sr_drive_check #(
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  output logic             S,
  output logic             R,
  input  logic             Q,
  output logic             rsp_valid,
  output logic             rsp_pass,
  output logic             rsp_skip,
  output logic             rsp_q,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
`ifdef SR_DRIVE_CHECK_STICKY_ERR_EN
  ,
  output logic             err_sticky
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [3:0]       SETTLE_V = 4'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0] state;
  logic [1:0] op;
  logic [3:0] wait_cnt;
  logic       exp;
  logic       exp_known;
  logic       cmp_pass;
  logic       cmp_skip;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == CNT_MAX) begin
      sat_inc = c;
    end else begin
      sat_inc = c + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Compare sampled Q to the model; an X/Z Q falls into the else branch and scores a fail
  always_comb begin
    cmp_pass = 1'b0;
    cmp_skip = 1'b0;
    if (!exp_known) begin
      cmp_skip = 1'b1;
    end else if (Q == exp) begin
      cmp_pass = 1'b1;
    end else begin
      cmp_pass = 1'b0;
    end
  end

  // Command FSM, drive pulse, settle timer, result capture, reference model and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      op        <= 2'b00;
      wait_cnt  <= 4'd0;
      cmd_ready <= 1'b1;
      S         <= 1'b0;
      R         <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_pass  <= 1'b0;
      rsp_skip  <= 1'b0;
      rsp_q     <= 1'b0;
      exp       <= 1'b0;
      exp_known <= 1'b0;
      pass_cnt  <= {CNT_W{1'b0}};
      fail_cnt  <= {CNT_W{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op        <= cmd_op;
            S         <= cmd_op[1];
            R         <= cmd_op[0];
            cmd_ready <= 1'b0;
            state     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          S        <= 1'b0;
          R        <= 1'b0;
          wait_cnt <= SETTLE_V;
          state    <= ST_WAIT;
          case (op)
            2'b10: begin exp <= 1'b1; exp_known <= 1'b1; end
            2'b01: begin exp <= 1'b0; exp_known <= 1'b1; end
            2'b11: exp_known <= 1'b0;
            default: ;
          endcase
        end
        ST_WAIT: begin
          if (wait_cnt <= 4'd1) begin
            rsp_q     <= Q;
            rsp_pass  <= cmp_pass;
            rsp_skip  <= cmp_skip;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
          if (rsp_pass) begin
            pass_cnt <= sat_inc(pass_cnt);
          end else if (!rsp_skip) begin
            fail_cnt <= sat_inc(fail_cnt);
          end
        end
        default: begin
          S         <= 1'b0;
          R         <= 1'b0;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SR_DRIVE_CHECK_STICKY_ERR_EN
  // Latch the first failing result until reset, independent of counter saturation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (state == ST_RESP && !rsp_pass && !rsp_skip) begin
      err_sticky <= 1'b1;
    end
  end
`endif

endmodule
